// File: rtl/fir_pkg.sv
// Shared constants for the FIR filter and the blocks around it.
// The FIR output width and gain shift are used on both the source side
// and by the output formatter, so they live here in one place.
package fir_pkg;

    // Width of the FIR accumulator output (yout).
    localparam int FIR_OUT_W      = 29;

    // Width of a formatted sample delivered to the DAC/stream side.
    localparam int SAMPLE_W       = 12;

    // The coefficient sum is 2098, close enough to 2^11 that a shift by 11
    // removes the DC gain with a small (~2.4 %) residual gain error.
    localparam int FIR_GAIN_SHIFT = 11;

    // Exact coefficient sum, used when checking the end-to-end gain.
    localparam int FIR_COEF_SUM   = 2098;

    // Default number of entries in the output FIFO.
    localparam int FMT_FIFO_DEPTH = 4;

endpackage

// File: rtl/fir_sfifo.sv
// Synchronous first-word-fall-through FIFO.
// rdata always shows the head entry while the FIFO is non-empty and reads
// as zero when empty, so the consumer never sees stale storage.
// Occupancy is tracked by an explicit level counter; full/empty come from
// it, so pointers simply wrap modulo DEPTH (DEPTH is a power of two).
// A push while full is accepted only when a pop happens on the same edge;
// the popped slot is the one being overwritten, so ordering is preserved.
module fir_sfifo
    import fir_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int DEPTH = FMT_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    rd_ptr_d;
    logic [AW:0]      level_q;
    logic [AW:0]      level_d;

    logic             pop_ok;
    logic             push_ok;

    assign full   = (level_q == (AW+1)'(DEPTH));
    assign empty  = (level_q == '0);
    assign level  = level_q;
    assign rdata  = empty ? '0 : mem_q[rd_ptr_q];

    // Qualify requests so an illegal pop/push never corrupts the pointers.
    always_comb begin
        pop_ok  = pop & ~empty;
        push_ok = push & (~full | pop_ok);
    end

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers, cleared by the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage write; contents need no reset because empty masks rdata.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/fir_out_formatter.sv
// Output formatter for the parallel FIR filter.
// Each FIR result is rounded half-up, shifted right by SHIFT to remove the
// filter DC gain, saturated to an OUT_W-bit unsigned sample and pushed into
// a small FWFT FIFO that feeds a ready/valid consumer.
//
// Handshake: a sample transfers on every rising edge where out_valid and
// out_ready are both high; out_valid depends only on FIFO occupancy and
// never on out_ready, and out_data is stable while out_valid is high and
// out_ready is low.
//
// The FIR cannot be stalled, so a formatted sample that finds the FIFO full
// (with no pop on the same edge) is dropped and the sticky overflow flag is
// raised. overflow is cleared by reset or by clear; a drop wins over clear.
module fir_out_formatter
    import fir_pkg::*;
#(
    parameter int IN_W  = FIR_OUT_W,
    parameter int OUT_W = SAMPLE_W,
    parameter int SHIFT = FIR_GAIN_SHIFT,
    parameter int DEPTH = FMT_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [IN_W-1:0]          in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     sat_flag,
    output logic                     overflow,
    input  logic                     clear
);

    // Half an output LSB, added before the shift for round-half-up.
    localparam logic [IN_W:0] RND_ADD = (IN_W+1)'(1) << (SHIFT-1);
    // Largest representable output sample, extended to the working width.
    localparam logic [IN_W:0] OUT_MAX = (IN_W+1)'((64'd1 << OUT_W) - 64'd1);

    // Rounding arithmetic, one bit wider than the input so it cannot wrap.
    logic [IN_W:0]    sum_w;
    logic [IN_W:0]    rnd_w;
    logic             clip_w;
    logic [OUT_W-1:0] fmt_val_w;

    // Format stage registers.
    logic             fmt_v_q;
    logic             fmt_v_d;
    logic [OUT_W-1:0] fmt_data_q;
    logic [OUT_W-1:0] fmt_data_d;
    logic             sat_q;
    logic             sat_d;

    // Overflow reporting.
    logic             ovf_q;
    logic             ovf_d;

    // FIFO control.
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop_w;
    logic             push_w;
    logic             drop_w;

    // Round half-up, shift, and clip to the output range.
    always_comb begin
        sum_w     = {1'b0, in_data} + RND_ADD;
        rnd_w     = sum_w >> SHIFT;
        clip_w    = (rnd_w > OUT_MAX);
        fmt_val_w = clip_w ? {OUT_W{1'b1}} : rnd_w[OUT_W-1:0];
    end

    // Format stage next-state: valid and sat follow in_valid by one cycle,
    // data holds its last value when no new sample arrives.
    always_comb begin
        fmt_v_d    = in_valid;
        sat_d      = in_valid & clip_w;
        fmt_data_d = in_valid ? fmt_val_w : fmt_data_q;
    end

    // Format stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fmt_v_q    <= 1'b0;
            fmt_data_q <= '0;
            sat_q      <= 1'b0;
        end else begin
            fmt_v_q    <= fmt_v_d;
            fmt_data_q <= fmt_data_d;
            sat_q      <= sat_d;
        end
    end

    // Push/pop decisions; a push at full is legal only alongside a pop.
    always_comb begin
        pop_w  = ~fifo_empty & out_ready;
        push_w = fmt_v_q & (~fifo_full | pop_w);
        drop_w = fmt_v_q & fifo_full & ~pop_w;
    end

    // Sticky overflow: a drop sets it and overrides a simultaneous clear.
    always_comb begin
        ovf_d = ovf_q;
        if (drop_w) begin
            ovf_d = 1'b1;
        end else if (clear) begin
            ovf_d = 1'b0;
        end
    end

    // Overflow register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    fir_sfifo #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_w),
        .pop   (pop_w),
        .wdata (fmt_data_q),
        .rdata (out_data),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_valid = ~fifo_empty;
    assign sat_flag  = sat_q;
    assign overflow  = ovf_q;

endmodule
